fp_mul_result_queue: RTL

Credit-controlled issue and result-buffering wrapper placed around the 32-bit floating-point multiplier (`FPMul32`, fixed latency, no backpressure). It accepts operand pairs on a valid/ready port and drives the multiplier's trigger and operand inputs. It captures every multiplier result into a FIFO and presents results in order on a valid/ready response port. Credit accounting guarantees that a result never arrives to a full FIFO, so downstream stalls propagate upstream without losing data.

---
 rtl/fp_mul_result_queue_if.sv | 43 ++++
 rtl/fp_mul_result_queue.sv | 111 +++++++++++
 2 files changed

// File: rtl/fp_mul_result_queue_if.sv
// Bundles the request, multiplier and response signals of fp_mul_result_queue.
// slave is the queue side and master is the side that offers requests and owns the multiplier.
interface fp_mul_result_queue_if #(
  parameter int TOKEN_W = 1
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds valid and its payload steady until that transfer.
  // The consumer may raise or drop ready freely, and ready never depends on valid.
  logic               req_valid;
  logic               req_ready;
  logic [TOKEN_W-1:0] req_token;
  logic [31:0]        req_a;
  logic [31:0]        req_b;

  logic [TOKEN_W-1:0] mul_in_0;
  logic [31:0]        mul_in_1;
  logic [31:0]        mul_in_2;
  logic [TOKEN_W-1:0] mul_out_0;
  logic [31:0]        mul_out_1;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [TOKEN_W-1:0] rsp_token;
  logic [31:0]        rsp_data;

  modport slave (
    input  req_valid, req_token, req_a, req_b,
    output req_ready,
    output mul_in_0, mul_in_1, mul_in_2,
    input  mul_out_0, mul_out_1,
    output rsp_valid, rsp_token, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_token, req_a, req_b,
    input  req_ready,
    input  mul_in_0, mul_in_1, mul_in_2,
    output mul_out_0, mul_out_1,
    input  rsp_valid, rsp_token, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/fp_mul_result_queue.sv
// Credit-controlled issue and in-order result FIFO around a fixed-latency FPMul32.
// Define FP_MUL_RESULT_QUEUE_FTZ_EN to flush denormal results to signed zero on capture.
module fp_mul_result_queue #(
  parameter int tokenWidth = 1,
  parameter int latency    = 11,
  parameter int depth      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  fp_mul_result_queue_if.slave    bus,
  output logic [$clog2(depth):0]  dbg_free
);
  localparam int PTR_W   = $clog2(depth);
  localparam int ENTRY_W = tokenWidth + 32;
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] FREE_INIT = (PTR_W + 1)'(depth);

  logic [PTR_W:0]       free_q, free_d;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [latency-1:0]   vpipe_q, vpipe_d;
  logic [ENTRY_W-1:0]   mem_q [depth];

  logic                 req_ready;
  logic                 issue;
  logic                 pop;
  logic                 capture;
  logic                 empty;
  logic                 full;
  logic [31:0]          cap_res;
  logic [ENTRY_W-1:0]   cap_entry;
  logic [ENTRY_W-1:0]   head;
  logic [PTR_W-1:0]     wr_idx;
  logic [PTR_W-1:0]     rd_idx;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  // A credit covers a slot from issue until its result is popped, so capture always has room.
  assign req_ready = reset && (free_q != '0);
  assign issue     = bus.req_valid && req_ready;
  assign pop       = bus.rsp_valid && bus.rsp_ready;
  assign capture   = vpipe_q[0];

  always_comb begin
    cap_res = bus.mul_out_1;
`ifdef FP_MUL_RESULT_QUEUE_FTZ_EN
    if ((cap_res[30:23] == 8'h00) && (cap_res[22:0] != 23'h0)) begin
      cap_res = {cap_res[31], 31'h0};
    end
`endif
    cap_entry = {bus.mul_out_0, cap_res};
  end

  always_comb begin
    vpipe_d = vpipe_q >> 1;
    vpipe_d[latency-1] = issue;

    free_d = free_q;
    case ({issue, pop})
      2'b10:   free_d = free_q - PTR_ONE;
      2'b01:   free_d = free_q + PTR_ONE;
      default: free_d = free_q;
    endcase

    wr_ptr_d = capture ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_q   <= FREE_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vpipe_q  <= '0;
    end else begin
      free_q   <= free_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vpipe_q  <= vpipe_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (capture) begin
      mem_q[wr_idx] <= cap_entry;
    end
  end

  assign head = mem_q[rd_idx];

  assign bus.req_ready = req_ready;
  assign bus.mul_in_0  = issue ? bus.req_token : '0;
  assign bus.mul_in_1  = issue ? bus.req_a : 32'h0;
  assign bus.mul_in_2  = issue ? bus.req_b : 32'h0;

  assign bus.rsp_valid = !empty;
  assign bus.rsp_token = empty ? '0 : head[ENTRY_W-1:32];
  assign bus.rsp_data  = empty ? 32'h0 : head[31:0];

  assign dbg_free = free_q;

  a_no_capture_when_full: assert property (@(posedge clock) disable iff (!reset)
    capture |-> !full);
  a_free_bounded: assert property (@(posedge clock) disable iff (!reset)
    free_q <= FREE_INIT);
endmodule
